// File: rtl/mmio_bus_arbiter.sv
// rtl/mmio_bus_arbiter.sv - two-master MMIO arbiter with bounded locked bursts.
// Define MMIO_ARB_ROUND_ROBIN_EN for alternating tie-break; default is fixed M0 priority.
module mmio_bus_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int HOLD_MAX = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                m0_req,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W/8-1:0] m0_be,
    input  logic                m0_wren,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic                m0_lock,
    output logic                m0_gnt,
    output logic                m0_rvalid,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W/8-1:0] m1_be,
    input  logic                m1_wren,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic                m1_lock,
    output logic                m1_gnt,
    output logic                m1_rvalid,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic [ADDR_W-1:0]   s_address,
    output logic [DATA_W/8-1:0] s_byteena,
    output logic                s_clken,
    output logic [DATA_W-1:0]   s_data,
    output logic                s_wren,
    input  logic [DATA_W-1:0]   s_q
);
    localparam int HOLD_W = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_t;

    owner_t            owner_q, owner_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_base;
    logic              rv0_q, rv1_q;
    logic              lock_w;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
    logic              last_q, last_d;
`endif

    // Grants are gated by reset_n so nothing reaches the slave while in reset.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (reset_n) begin
            if (owner_q == OWN_M0 && m0_req) begin
                m0_gnt = 1'b1;
            end else if (owner_q == OWN_M1 && m1_req) begin
                m1_gnt = 1'b1;
            end else if (m0_req && m1_req) begin
`ifdef MMIO_ARB_ROUND_ROBIN_EN
                m0_gnt = last_q;
                m1_gnt = ~last_q;
`else
                m0_gnt = 1'b1;
`endif
            end else begin
                m0_gnt = m0_req;
                m1_gnt = m1_req;
            end
        end
    end

    always_comb begin
        s_clken   = m0_gnt | m1_gnt;
        s_address = '0;
        s_byteena = '0;
        s_data    = '0;
        s_wren    = 1'b0;
        if (m0_gnt) begin
            s_address = m0_addr;
            s_byteena = m0_be;
            s_data    = m0_wdata;
            s_wren    = m0_wren;
        end else if (m1_gnt) begin
            s_address = m1_addr;
            s_byteena = m1_be;
            s_data    = m1_wdata;
            s_wren    = m1_wren;
        end
    end

    // A winner that was not already the owner starts its burst count from zero.
    always_comb begin
        owner_d   = owner_q;
        hold_d    = hold_q;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        hold_base = ((m0_gnt && owner_q == OWN_M0) || (m1_gnt && owner_q == OWN_M1)) ? hold_q : '0;
        lock_w    = m0_gnt ? m0_lock : m1_lock;
        if (m0_gnt || m1_gnt) begin
            if (lock_w && (int'(hold_base) + 1 < HOLD_MAX)) begin
                owner_d = m0_gnt ? OWN_M0 : OWN_M1;
                hold_d  = hold_base + HOLD_W'(1);
            end else begin
                owner_d = OWN_NONE;
                hold_d  = '0;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
                last_d  = m1_gnt;
`endif
            end
        end else begin
            owner_d = OWN_NONE;
            hold_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= OWN_NONE;
            hold_q  <= '0;
            rv0_q   <= 1'b0;
            rv1_q   <= 1'b0;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            owner_q <= owner_d;
            hold_q  <= hold_d;
            rv0_q   <= m0_gnt & ~m0_wren;
            rv1_q   <= m1_gnt & ~m1_wren;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign m0_rvalid = rv0_q;
    assign m1_rvalid = rv1_q;
    assign m0_rdata  = rv0_q ? s_q : '0;
    assign m1_rdata  = rv1_q ? s_q : '0;

endmodule

// File: tb/tb_mmio_bus_arbiter.sv
// tb/tb_mmio_bus_arbiter.sv - scoreboard bench for mmio_bus_arbiter.
module tb_mmio_bus_arbiter;
`ifdef MMIO_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock, reset_n;
    logic        m0_req, m0_wren, m0_lock, m0_gnt, m0_rvalid;
    logic [13:0] m0_addr;
    logic [3:0]  m0_be;
    logic [31:0] m0_wdata, m0_rdata;
    logic        m1_req, m1_wren, m1_lock, m1_gnt, m1_rvalid;
    logic [13:0] m1_addr;
    logic [3:0]  m1_be;
    logic [31:0] m1_wdata, m1_rdata;
    logic [13:0] s_address;
    logic [3:0]  s_byteena;
    logic        s_clken, s_wren;
    logic [31:0] s_data, s_q;

    mmio_bus_arbiter #(.ADDR_W(14), .DATA_W(32), .HOLD_MAX(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_be(m0_be), .m0_wren(m0_wren),
        .m0_wdata(m0_wdata), .m0_lock(m0_lock), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_be(m1_be), .m1_wren(m1_wren),
        .m1_wdata(m1_wdata), .m1_lock(m1_lock), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .s_address(s_address), .s_byteena(s_byteena), .s_clken(s_clken),
        .s_data(s_data), .s_wren(s_wren), .s_q(s_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] slave_f(input logic [13:0] a);
        return {4'hC, a, ~a};
    endfunction

    always @(posedge clock) s_q <= slave_f(s_address);

    typedef struct packed {
        logic        req;
        logic        lock;
        logic        wren;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } mreq_t;

    typedef struct {
        int          cyc;
        int          m;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        wren;
    } gexp_t;

    typedef struct {
        int          cyc;
        int          m;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input mreq_t q0, input mreq_t q1);
        m0_req = q0.req; m0_lock = q0.lock; m0_wren = q0.wren;
        m0_addr = q0.addr; m0_be = q0.be; m0_wdata = q0.wdata;
        m1_req = q1.req; m1_lock = q1.lock; m1_wren = q1.wren;
        m1_addr = q1.addr; m1_be = q1.be; m1_wdata = q1.wdata;
    endtask

    // w: expected winner this cycle (-1 none); rv_ok: whether a read should return data.
    task automatic apply(input mreq_t q0, input mreq_t q1, input int w, input bit rv_ok);
        mreq_t q;
        drive(q0, q1);
        if (w >= 0) begin
            q = (w == 0) ? q0 : q1;
            gq.push_back('{cyc, w, q.addr, q.be, q.wdata, q.wren});
            if (!q.wren && rv_ok) rq.push_back('{cyc + 1, w, slave_f(q.addr)});
        end
    endtask

    task automatic step(input mreq_t q0, input mreq_t q1, input int w, input bit rv_ok);
        @(posedge clock);
        #1;
        apply(q0, q1, w, rv_ok);
    endtask

    always @(negedge clock) begin : monitor
        gexp_t ge;
        rexp_t re;
        if (m0_gnt || m1_gnt) begin
            if (gq.size() == 0) begin
                chk("unexpected_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
            end else begin
                ge = gq.pop_front();
                chk("gnt_cycle", 64'(cyc), 64'(ge.cyc));
                chk("gnt_vec", {62'd0, m1_gnt, m0_gnt}, (ge.m == 0) ? 64'd1 : 64'd2);
                chk("s_fields", {11'd0, s_clken, s_wren, s_address, s_byteena, s_data},
                    {11'd0, 1'b1, ge.wren, ge.addr, ge.be, ge.wdata});
            end
        end else begin
            chk("s_idle", {12'd0, s_clken, s_wren, s_address, s_byteena, s_data}, 64'd0);
        end
        if (m0_rvalid || m1_rvalid) begin
            if (rq.size() == 0) begin
                chk("unexpected_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
            end else begin
                re = rq.pop_front();
                chk("rv_cycle", 64'(cyc), 64'(re.cyc));
                chk("rv_vec", {62'd0, m1_rvalid, m0_rvalid}, (re.m == 0) ? 64'd1 : 64'd2);
                chk("rdata", (re.m == 0) ? {32'd0, m0_rdata} : {32'd0, m1_rdata}, {32'd0, re.data});
            end
        end else begin
            chk("rdata_idle", {m0_rdata, m1_rdata}, 64'd0);
        end
    end

    initial begin
        mreq_t idle, b0, b1, r4, w4, z7, l1, a40, k0, m1r, r1x;
        idle = '0;
        b0  = '{req: 1'b1, lock: 1'b0, wren: 1'b0, addr: 14'h0010, be: 4'hF, wdata: 32'h0};
        b1  = '{req: 1'b1, lock: 1'b0, wren: 1'b0, addr: 14'h0020, be: 4'hF, wdata: 32'h0};
        r4  = '{req: 1'b1, lock: 1'b0, wren: 1'b0, addr: 14'h0004, be: 4'hF, wdata: 32'h0};
        w4  = '{req: 1'b1, lock: 1'b0, wren: 1'b1, addr: 14'h0004, be: 4'h3, wdata: 32'hDEADBEEF};
        z7  = '{req: 1'b1, lock: 1'b0, wren: 1'b0, addr: 14'h0007, be: 4'h0, wdata: 32'h0};
        l1  = '{req: 1'b1, lock: 1'b1, wren: 1'b0, addr: 14'h0030, be: 4'hF, wdata: 32'h0};
        a40 = '{req: 1'b1, lock: 1'b0, wren: 1'b0, addr: 14'h0040, be: 4'hF, wdata: 32'h0};
        k0  = '{req: 1'b1, lock: 1'b1, wren: 1'b1, addr: 14'h0050, be: 4'hC, wdata: 32'h12345678};
        m1r = '{req: 1'b1, lock: 1'b0, wren: 1'b0, addr: 14'h0060, be: 4'hF, wdata: 32'h0};
        r1x = '{req: 1'b1, lock: 1'b0, wren: 1'b0, addr: 14'h0070, be: 4'hF, wdata: 32'h0};

        reset_n = 1'b0;
        drive(b0, b1);
        repeat (3) begin
            @(negedge clock);
            chk("rst_gnt", {62'd0, m1_gnt, m0_gnt}, 64'd0);
            chk("rst_clken", {63'd0, s_clken}, 64'd0);
            chk("rst_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
        end

        @(posedge clock);
        #1;
        reset_n = 1'b1;
        apply(b0, b1, 0, 1'b1);

        step(b0, b1, RR ? 1 : 0, 1'b1);
        step(b0, b1, 0, 1'b1);
        step(b0, b1, RR ? 1 : 0, 1'b1);
        step(idle, idle, -1, 1'b0);

        step(r4, idle, 0, 1'b1);
        step(w4, idle, 0, 1'b1);
        step(idle, z7, 1, 1'b1);
        step(idle, idle, -1, 1'b0);

        step(idle, l1, 1, 1'b1);
        repeat (7) step(a40, l1, 1, 1'b1);
        step(a40, l1, 0, 1'b1);
        step(idle, idle, -1, 1'b0);

        step(k0, idle, 0, 1'b1);
        step(k0, m1r, 0, 1'b1);
        step(idle, m1r, 1, 1'b1);
        step(idle, idle, -1, 1'b0);

        step(idle, r1x, 1, 1'b0);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        drive(idle, idle);
        repeat (2) begin
            @(negedge clock);
            chk("rst_mid_rvalid", {62'd0, m1_rvalid, m0_rvalid}, 64'd0);
        end
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step(idle, idle, -1, 1'b0);
        step(idle, idle, -1, 1'b0);

        step(b0, b1, 0, 1'b1);
        step(idle, idle, -1, 1'b0);
        step(idle, idle, -1, 1'b0);
        @(negedge clock);

        chk("gnt_queue_left", 64'(gq.size()), 64'd0);
        chk("rv_queue_left", 64'(rq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
